// File: rtl/cpu_step_ctrl_if.sv
// +----------------------------------------------------------------------+
// | cpu_step_ctrl_if                                                     |
// | Board/CPU-side signal bundle for the run/step/breakpoint sequencer.  |
// | Breakpoint signals exist only with CPU_STEP_BREAKPOINT_EN defined.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface cpu_step_ctrl_if;
  logic        clk_click;
  logic        run_sw;
  logic [15:0] pc_in;
  logic        fetch_state;
`ifdef CPU_STEP_BREAKPOINT_EN
  logic [15:0] bp_addr;
  logic        bp_valid;
`endif
  logic        cpu_en;
  logic        halted;
  logic        bp_hit;
  logic [1:0]  mode;

`ifdef CPU_STEP_BREAKPOINT_EN
  modport master (output clk_click, run_sw, pc_in, fetch_state, bp_addr, bp_valid,
                  input  cpu_en, halted, bp_hit, mode);
  modport slave  (input  clk_click, run_sw, pc_in, fetch_state, bp_addr, bp_valid,
                  output cpu_en, halted, bp_hit, mode);
`else
  modport master (output clk_click, run_sw, pc_in, fetch_state,
                  input  cpu_en, halted, bp_hit, mode);
  modport slave  (input  clk_click, run_sw, pc_in, fetch_state,
                  output cpu_en, halted, bp_hit, mode);
`endif
endinterface

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// +----------------------------------------------------------------------+
// | cpu_step_ctrl                                                        |
// | Run/step/breakpoint sequencer gating the CPU control unit with a     |
// | one-cycle enable. Optional breakpoint support is compiled in with    |
// | the macro CPU_STEP_BREAKPOINT_EN.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu_step_ctrl #(
  parameter int DIV        = 10000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  cpu_step_ctrl_if.slave bus
);

  localparam int             PW       = $clog2(DIV);
  localparam int             DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    BP_HALT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sync1;
  logic            sync2;
  logic            deb;
  logic            deb_prev;
  logic [DW-1:0]   deb_cnt;
  logic            press;
  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic            left;
  logic            bp_match;
  logic            en;
  logic            halted_r;
  logic [1:0]      mode_r;

  // Synchronize the raw button and accept a new level only after DEB_CYCLES stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync1    <= bus.clk_click;
      sync2    <= sync1;
      deb_prev <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign press = deb & ~deb_prev;
  assign tick  = (pre_cnt == PRE_LAST);

`ifdef CPU_STEP_BREAKPOINT_EN
  logic skip;
  logic run_prev;

  // A resumed breakpoint instruction must not re-trigger until its fetch has been left
  always_ff @(posedge clk) begin
    if (rst) begin
      skip     <= 1'b0;
      run_prev <= 1'b0;
    end else begin
      run_prev <= bus.run_sw;
      if (((state == HALT) || (state == BP_HALT)) && (state_nxt == STEP))
        skip <= 1'b1;
      else if ((state == BP_HALT) && (state_nxt == RUN))
        skip <= 1'b1;
      else if (!bus.fetch_state)
        skip <= 1'b0;
    end
  end

  assign bp_match = (state == RUN) & bus.bp_valid & bus.fetch_state &
                    (bus.pc_in == bus.bp_addr) & ~skip;
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc_in;
  assign bp_match  = 1'b0;
`endif

  // Next state and the CPU enable; stopping only ever happens at an instruction boundary
  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    case (state)
      HALT: begin
        if (bus.run_sw)
          state_nxt = RUN;
        else if (press)
          state_nxt = STEP;
      end
      RUN: begin
        if (!bus.run_sw && bus.fetch_state)
          state_nxt = HALT;
        else if (bp_match)
          state_nxt = BP_HALT;
        else
          en = tick;
      end
      STEP: begin
        if (bus.fetch_state && left)
          state_nxt = bus.run_sw ? RUN : HALT;
        else
          en = 1'b1;
      end
      BP_HALT: begin
`ifdef CPU_STEP_BREAKPOINT_EN
        if (press)
          state_nxt = STEP;
        else if (bus.run_sw && !run_prev)
          state_nxt = RUN;
`else
        state_nxt = HALT;
`endif
      end
      default: state_nxt = HALT;
    endcase
  end

  // State register, registered status outputs, prescaler and step-progress flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HALT;
      halted_r <= 1'b1;
      mode_r   <= 2'd0;
      pre_cnt  <= '0;
      left     <= 1'b0;
    end else begin
      state    <= state_nxt;
      halted_r <= (state_nxt == HALT) || (state_nxt == BP_HALT);
      mode_r   <= state_nxt;
      if (((state_nxt == RUN) && (state != RUN)) || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + PW'(1);
      if ((state_nxt == STEP) && (state != STEP))
        left <= 1'b0;
      else if ((state == STEP) && en && bus.fetch_state)
        left <= 1'b1;
    end
  end

`ifdef CPU_STEP_BREAKPOINT_EN
  logic bp_hit_r;

  // Breakpoint-hit flag follows the BP_HALT state
  always_ff @(posedge clk) begin
    if (rst)
      bp_hit_r <= 1'b0;
    else
      bp_hit_r <= (state_nxt == BP_HALT);
  end

  assign bus.bp_hit = bp_hit_r;
`else
  assign bus.bp_hit = 1'b0;
`endif

  assign bus.cpu_en = en;
  assign bus.halted = halted_r;
  assign bus.mode   = mode_r;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_cpu_step_ctrl                                                     |
// | Self-checking bench: directed scenarios plus randomized stimulus     |
// | against a behavioural model. Honours CPU_STEP_BREAKPOINT_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cpu_step_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_step_ctrl_if bus();

  cpu_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Environment: a 4-state instruction CPU; PC advances when an instruction completes
  int          cpu_st = 0;
  logic [15:0] pc     = '0;

  // Behavioural model of the sequencer (mode: 0 halt, 1 run, 2 step, 3 bp halt)
  int  m_mode  = 0;
  int  m_since = 0;   // edges since the last RUN entry
  bit  m_left  = 0;
  bit  m_skip  = 0;
  bit  m_runp  = 0;
  bit  m_deb   = 0;
  bit  m_press = 0;
  bit  hist[$];       // raw button samples, newest last
  bit  syn[$];        // synced samples differing from the debounced level since last agreement
  bit  chk_on  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_bpm();
`ifdef CPU_STEP_BREAKPOINT_EN
    return (m_mode == 1) && bus.bp_valid && bus.fetch_state &&
           (bus.pc_in == bus.bp_addr) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_en();
    case (m_mode)
      1: return ((m_since % DIV) == DIV - 1) && !m_bpm() && !(!bus.run_sw && bus.fetch_state);
      2: return !(bus.fetch_state && m_left);
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model across one clock edge using the inputs present before the edge
  task automatic model_edge();
    bit en_c, bpm, fe, rs, pr, set_skip, synced;
    int nm;
    if (rst) begin
      m_mode = 0; m_left = 0; m_skip = 0; m_runp = 0; m_deb = 0; m_press = 0; m_since = 0;
      hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
      syn.delete();
      return;
    end
    en_c = m_en(); bpm = m_bpm(); fe = bus.fetch_state; rs = bus.run_sw; pr = m_press;
    nm = m_mode; set_skip = 0;
    case (m_mode)
      0: if (rs) begin nm = 1; m_since = 0; end
         else if (pr) begin nm = 2; set_skip = 1; m_left = 0; end
      1: if (!rs && fe) nm = 0;
         else if (bpm) nm = 3;
         else m_since++;
      2: if (fe && m_left) begin nm = rs ? 1 : 0; m_since = 0; end
         else if (fe && en_c) m_left = 1;
      default: if (pr) begin nm = 2; set_skip = 1; m_left = 0; end
               else if (rs && !m_runp) begin nm = 1; set_skip = 1; m_since = 0; end
    endcase
    if (set_skip) m_skip = 1;
    else if (!fe) m_skip = 0;
    m_runp = rs;
    m_mode = nm;
    // Button: the synced value lags the raw pin by two edges
    synced = hist[hist.size() - 2];
    hist.push_back(bus.clk_click);
    if (hist.size() > 4) void'(hist.pop_front());
    m_press = 0;
    if (synced == m_deb) syn.delete();
    else begin
      syn.push_back(synced);
      if (syn.size() >= DEB) begin
        m_deb = synced; m_press = synced; syn.delete();
      end
    end
  endtask

  // One clock: model and environment both advance on the edge
  task automatic cyc();
    logic en_d;
    #1;
    en_d = bus.cpu_en;
    @(posedge clk);
    model_edge();
    if (rst) chk_on = 1;
    #1;
    if (en_d === 1'b1) begin
      cpu_st = (cpu_st + 1) % 4;
      if (cpu_st == 0) pc = pc + 16'd1;
    end
    bus.fetch_state = (cpu_st == 0);
    bus.pc_in       = pc;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_cpu_en", {31'd0, bus.cpu_en}, {31'd0, m_en()});
      check("cyc_mode",   {30'd0, bus.mode},   32'(m_mode));
      check("cyc_halted", {31'd0, bus.halted}, {31'd0, (m_mode == 0) || (m_mode == 3)});
      check("cyc_bp_hit", {31'd0, bus.bp_hit}, {31'd0, m_mode == 3});
    end
  end

  int          n_en;
  int          to;
  int          hold;
  logic [11:0] pat;
  bit          seen;

  initial begin
    bus.clk_click = 0; bus.run_sw = 0; bus.pc_in = 0; bus.fetch_state = 1;
`ifdef CPU_STEP_BREAKPOINT_EN
    bus.bp_addr = 0; bus.bp_valid = 0;
`endif
    // Reset held two cycles with inputs toggling
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_cpu_en", {31'd0, bus.cpu_en}, 0);
      check("rst_halted", {31'd0, bus.halted}, 1);
      check("rst_mode",   {30'd0, bus.mode},   0);
      bus.clk_click = ~bus.clk_click;
      bus.run_sw    = ~bus.run_sw;
    end
    rst = 0;
    cyc();
    check("post_rst_mode",   {30'd0, bus.mode},   0);
    check("post_rst_halted", {31'd0, bus.halted}, 1);
    check("post_rst_cpu_en", {31'd0, bus.cpu_en}, 0);
    repeat (6) cyc();

    // Ten one-cycle glitches must never produce a press
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.clk_click = 1; cyc();
      bus.clk_click = 0; cyc(); cyc();
      if (bus.mode != 2'd0) seen = 1;
    end
    repeat (6) begin cyc(); if (bus.mode != 2'd0) seen = 1; end
    check("glitch_no_press", {31'd0, seen}, 0);

    // Clean press: STEP exactly 6 cycles after the rise, then one 4-state instruction
    bus.clk_click = 1;
    repeat (5) cyc();
    check("press_mode_t5", {30'd0, bus.mode}, 0);
    cyc();
    check("press_mode_t6", {30'd0, bus.mode}, 2);
    check("step_first_en", {31'd0, bus.cpu_en}, 1);
    n_en = 0; to = 0;
    while (bus.mode == 2'd2 && to < 20) begin
      if (bus.cpu_en) n_en++;
      if (to == 2) bus.clk_click = 0;
      cyc(); to++;
    end
    bus.clk_click = 0;
    check("step_en_count",   32'(n_en), 4);
    check("step_end_mode",   {30'd0, bus.mode}, 0);
    check("step_end_fetch",  {31'd0, bus.fetch_state}, 1);
    check("step_end_pc",     {16'd0, bus.pc_in}, 1);
    repeat (8) cyc();

    // Free-run: enables act on the 4th, 8th and 12th edge after entry
    bus.run_sw = 1;
    cyc();
    check("run_entry_mode", {30'd0, bus.mode}, 1);
    for (int i = 0; i < 12; i++) begin
      pat[i] = bus.cpu_en;
      cyc();
    end
    check("run_en_pattern", {20'd0, pat}, 32'h888);
    bus.run_sw = 0;
    n_en = 0; to = 0;
    while (bus.mode != 2'd0 && to < 20) begin
      if (bus.cpu_en) n_en++;
      cyc(); to++;
    end
    check("run_stop_en_count", 32'(n_en), 1);
    check("run_stop_mode",     {30'd0, bus.mode}, 0);
    check("run_stop_fetch",    {31'd0, bus.fetch_state}, 1);
    check("run_stop_pc",       {16'd0, bus.pc_in}, 2);

    // Breakpoint at 0x0003 running from PC 0
    pc = 0; bus.pc_in = 0;
`ifdef CPU_STEP_BREAKPOINT_EN
    bus.bp_addr = 16'h0003; bus.bp_valid = 1;
    bus.run_sw = 1;
    to = 0;
    while (bus.mode != 2'd3 && to < 100) begin cyc(); to++; end
    check("bp_mode",   {30'd0, bus.mode},   3);
    check("bp_hit",    {31'd0, bus.bp_hit}, 1);
    check("bp_pc",     {16'd0, bus.pc_in},  3);
    check("bp_no_en",  {31'd0, bus.cpu_en}, 0);
    bus.run_sw = 0;
    repeat (3) cyc();
    check("bp_hold_mode", {30'd0, bus.mode}, 3);
    bus.clk_click = 1;
    repeat (8) cyc();
    bus.clk_click = 0;
    to = 0;
    while (bus.mode != 2'd0 && to < 30) begin cyc(); to++; end
    check("bp_step_mode", {30'd0, bus.mode},  0);
    check("bp_step_pc",   {16'd0, bus.pc_in}, 4);
    check("bp_step_hit",  {31'd0, bus.bp_hit}, 0);
    bus.bp_valid = 0;
`else
    bus.run_sw = 1;
    seen = 0; to = 0;
    while (bus.pc_in != 16'd5 && to < 100) begin
      cyc(); to++;
      if (bus.bp_hit !== 1'b0 || bus.mode == 2'd3) seen = 1;
    end
    check("nobp_never_hit", {31'd0, seen}, 0);
    check("nobp_pc",        {16'd0, bus.pc_in}, 5);
    check("nobp_running",   {30'd0, bus.mode}, 1);
    bus.run_sw = 0;
    to = 0;
    while (bus.mode != 2'd0 && to < 30) begin cyc(); to++; end
    check("nobp_stop_mode", {30'd0, bus.mode}, 0);
`endif
    repeat (8) cyc();

    // Randomized stimulus, checked every cycle by the compare process
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) bus.run_sw = ~bus.run_sw;
      if (hold == 0) begin
        bus.clk_click = $urandom_range(0, 1);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
`ifdef CPU_STEP_BREAKPOINT_EN
      if ($urandom_range(0, 63) == 0) begin
        bus.bp_addr  = pc + 16'($urandom_range(0, 2));
        bus.bp_valid = $urandom_range(0, 1);
      end
`endif
      cyc();
    end
    rst = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
